// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, reset values,
// VEC field layout and the lowest-index priority helper.
package irq_ctrl_pkg;

    localparam int REG_W    = 8;
    localparam int ADDR_W   = 4;
    localparam int VEC_ID_W = 3;

    localparam logic [ADDR_W-1:0] REG_PEND  = 4'd0;
    localparam logic [ADDR_W-1:0] REG_MASK  = 4'd1;
    localparam logic [ADDR_W-1:0] REG_CLR   = 4'd2;
    localparam logic [ADDR_W-1:0] REG_MODE  = 4'd3;
    localparam logic [ADDR_W-1:0] REG_VEC   = 4'd4;
    localparam logic [ADDR_W-1:0] REG_SWSET = 4'd5;
    localparam logic [ADDR_W-1:0] REG_ROUTE = 4'd6;

    localparam logic [REG_W-1:0] MASK_RST  = 8'h00;
    localparam logic [REG_W-1:0] MODE_RST  = 8'hFF;
    localparam logic [REG_W-1:0] ROUTE_RST = 8'h10;

    typedef struct packed {
        logic                vld;
        logic [3:0]          rsvd;
        logic [VEC_ID_W-1:0] id;
    } vec_t;

    function automatic logic [VEC_ID_W-1:0] lowest_set(input logic [REG_W-1:0] v);
        logic [VEC_ID_W-1:0] id;
        id = '0;
        for (int i = REG_W - 1; i >= 0; i--) begin
            if (v[i]) id = VEC_ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// W-bit multi-flop synchroniser followed by a history flop; rise = sync & ~hist.
// Latency: STG clocks from input to sync_o; rise_o is combinational on the sync/history pair.
module sync_rise #(
    parameter int W        = 1,
    parameter int STG      = 2,
    parameter bit HIST_RST = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o
);

    logic [STG-1:0][W-1:0] r_stg;
    logic [W-1:0]          r_hist;

    // The whole chain resets to HIST_RST so a strobe held across reset release never looks like a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stg  <= {STG{{W{HIST_RST}}}};
            r_hist <= {W{HIST_RST}};
        end else begin
            r_stg  <= {r_stg[STG-2:0], d_i};
            r_hist <= r_stg[STG-1];
        end
    end

    assign sync_o = r_stg[STG-1];
    assign rise_o = r_stg[STG-1] & ~r_hist;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller folding N_SRC request lines onto the two 8051 INT pins via a byte register file.
// Latency: synced write rise commits on that clk; pending follows input by SYNC_STG+1 clk, INT one clk later.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC       = 5,
    parameter int SYNC_STG    = 2,
    parameter bit OUT_ACT_LOW = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bus_cs_i,
    input  logic              bus_rd_i,
    input  logic              bus_wr_i,
    input  logic [ADDR_W-1:0] bus_addr_i4,
    input  logic [REG_W-1:0]  bus_wrdat_i8,
    output logic [REG_W-1:0]  bus_rddat_o8,
    input  logic [N_SRC-1:0]  irq_src_i,
    output logic              cpu_int0_o,
    output logic              cpu_int1_o
);

    logic [N_SRC-1:0] w_src_sync;
    logic [N_SRC-1:0] w_src_rise;
    logic [1:0]       w_bus_sync;
    logic [1:0]       w_bus_rise;
    logic             w_wr_commit;
    logic             w_unused;

    sync_rise #(
        .W        (N_SRC),
        .STG      (SYNC_STG),
        .HIST_RST (1'b0)
    ) u_src_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (irq_src_i),
        .sync_o (w_src_sync),
        .rise_o (w_src_rise)
    );

    sync_rise #(
        .W        (2),
        .STG      (SYNC_STG),
        .HIST_RST (1'b1)
    ) u_bus_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    ({bus_rd_i, bus_wr_i}),
        .sync_o (w_bus_sync),
        .rise_o (w_bus_rise)
    );

    // Synced read strobe is reserved for a future read-to-clear register.
    assign w_unused    = &{1'b0, w_bus_sync, w_bus_rise[1], bus_wrdat_i8};
    assign w_wr_commit = w_bus_rise[0] & bus_cs_i;

    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_mode;
    logic [N_SRC-1:0] r_route;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_sticky;
    logic             r_int0;
    logic             r_int1;

    logic [N_SRC-1:0] w_wdat;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_swset;

    assign w_wdat = bus_wrdat_i8[N_SRC-1:0];

    always_comb begin
        w_clr   = '0;
        w_swset = '0;
        if (w_wr_commit) begin
            case (bus_addr_i4)
                REG_CLR:   w_clr   = w_wdat;
                REG_SWSET: w_swset = w_wdat;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mask  <= MASK_RST[N_SRC-1:0];
            r_mode  <= MODE_RST[N_SRC-1:0];
            r_route <= ROUTE_RST[N_SRC-1:0];
        end else if (w_wr_commit) begin
            case (bus_addr_i4)
                REG_MASK:  r_mask  <= w_wdat;
                REG_MODE:  r_mode  <= w_wdat;
                REG_ROUTE: r_route <= w_wdat;
                default:   ;
            endcase
        end
    end

    // Set terms are OR-ed after the clear mask so a same-clk set always wins.
    logic [N_SRC-1:0] w_sticky_nxt;
    logic [N_SRC-1:0] w_edge_nxt;
    logic [N_SRC-1:0] w_level_nxt;
    logic [N_SRC-1:0] w_pend_nxt;

    assign w_sticky_nxt = w_swset | (r_sticky & ~w_clr);
    assign w_edge_nxt   = w_src_rise | w_swset | (r_pend & ~w_clr);
    assign w_level_nxt  = w_src_sync | w_sticky_nxt;
    assign w_pend_nxt   = (r_mode & w_edge_nxt) | (~r_mode & w_level_nxt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend   <= '0;
            r_sticky <= '0;
        end else begin
            r_pend   <= w_pend_nxt;
            r_sticky <= w_sticky_nxt;
        end
    end

    logic [N_SRC-1:0] w_act;
    logic             w_act0;
    logic             w_act1;

    assign w_act  = r_pend & r_mask;
    assign w_act0 = |(w_act & ~r_route);
    assign w_act1 = |(w_act & r_route);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_int0 <= OUT_ACT_LOW;
            r_int1 <= OUT_ACT_LOW;
        end else begin
            r_int0 <= w_act0 ^ OUT_ACT_LOW;
            r_int1 <= w_act1 ^ OUT_ACT_LOW;
        end
    end

    assign cpu_int0_o = r_int0;
    assign cpu_int1_o = r_int1;

    logic [REG_W-1:0] w_act8;
    vec_t             w_vec;

    assign w_act8     = REG_W'(w_act);
    assign w_vec.vld  = |w_act;
    assign w_vec.rsvd = '0;
    assign w_vec.id   = lowest_set(w_act8);

    always_comb begin
        bus_rddat_o8 = '0;
        if (bus_cs_i) begin
            case (bus_addr_i4)
                REG_PEND:  bus_rddat_o8 = REG_W'(r_pend);
                REG_MASK:  bus_rddat_o8 = REG_W'(r_mask);
                REG_MODE:  bus_rddat_o8 = REG_W'(r_mode);
                REG_VEC:   bus_rddat_o8 = w_vec;
                REG_ROUTE: bus_rddat_o8 = REG_W'(r_route);
                default:   bus_rddat_o8 = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations queued at stimulus time, popped as outputs are sampled.
module tb_irq_ctrl;

    localparam logic [3:0] A_PEND  = 4'd0;
    localparam logic [3:0] A_MASK  = 4'd1;
    localparam logic [3:0] A_CLR   = 4'd2;
    localparam logic [3:0] A_MODE  = 4'd3;
    localparam logic [3:0] A_VEC   = 4'd4;
    localparam logic [3:0] A_SWSET = 4'd5;
    localparam logic [3:0] A_ROUTE = 4'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wdat = '0;
    logic [7:0] rdat;
    logic [4:0] src = '0;
    logic       int0;
    logic       int1;

    int n_checks = 0;
    int n_err    = 0;

    string      sb_tag[$];
    logic [7:0] sb_exp[$];

    irq_ctrl #(
        .N_SRC       (5),
        .SYNC_STG    (2),
        .OUT_ACT_LOW (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus_cs_i     (cs),
        .bus_rd_i     (rd),
        .bus_wr_i     (wr),
        .bus_addr_i4  (addr),
        .bus_wrdat_i8 (wdat),
        .bus_rddat_o8 (rdat),
        .irq_src_i    (src),
        .cpu_int0_o   (int0),
        .cpu_int1_o   (int1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    task automatic sb_pop(input logic [7:0] got);
        string      t;
        logic [7:0] e;
        if (sb_exp.size() == 0) begin
            t = "sb_empty";
            e = ~got;
        end else begin
            t = sb_tag.pop_front();
            e = sb_exp.pop_front();
        end
        chk(t, got, e);
    endtask

    // INT pins packed as {int1, int0}; 2'b11 is idle with active-low outputs.
    task automatic int_chk(input string tag, input logic [1:0] exp);
        sb_push(tag, {6'b0, exp});
        sb_pop({6'b0, int1, int0});
    endtask

    task automatic rd_reg(input string tag, input logic [3:0] a, input logic [7:0] exp,
                          input logic c = 1'b1);
        @(negedge clk);
        cs   = c;
        addr = a;
        sb_push(tag, exp);
        #1;
        sb_pop(rdat);
        cs = 1'b0;
    endtask

    // Returns at the negedge just after the commit edge, strobe still held.
    task automatic wr_begin(input logic [3:0] a, input logic [7:0] d, input logic c = 1'b1);
        @(negedge clk);
        cs   = c;
        addr = a;
        wdat = d;
        wr   = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wr_end();
        wr = 1'b0;
        cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d, input logic c = 1'b1);
        wr_begin(a, d, c);
        wr_end();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        int_chk("rst_int", 2'b11);
        rd_reg("rst_pend",  A_PEND,  8'h00);
        rd_reg("rst_mask",  A_MASK,  8'h00);
        rd_reg("rst_mode",  A_MODE,  8'h1F);
        rd_reg("rst_route", A_ROUTE, 8'h10);
        rd_reg("rst_vec",   A_VEC,   8'h00);

        // Edge source routed to INT0, exact latency
        wr_reg(A_MASK, 8'h1F);
        @(negedge clk);
        src[2] = 1'b1;
        sb_push("edge_int_e2", 8'h03);
        sb_push("edge_int_e3", 8'h02);
        @(negedge clk);
        src[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sb_pop({6'b0, int1, int0});
        @(negedge clk);
        sb_pop({6'b0, int1, int0});
        rd_reg("edge_pend", A_PEND, 8'h04);
        rd_reg("edge_vec",  A_VEC,  8'h82);
        wr_begin(A_CLR, 8'h04);
        sb_push("clr_int_commit", 8'h02);
        sb_push("clr_int_next",   8'h03);
        sb_pop({6'b0, int1, int0});
        @(negedge clk);
        sb_pop({6'b0, int1, int0});
        wr_end();
        rd_reg("clr_pend", A_PEND, 8'h00);

        // Level mode on INT1, CLR ignored while level high
        wr_reg(A_MODE,  8'h00);
        wr_reg(A_ROUTE, 8'h01);
        @(negedge clk);
        src[0] = 1'b1;
        repeat (4) @(negedge clk);
        int_chk("lvl_int_on", 2'b01);
        rd_reg("lvl_pend", A_PEND, 8'h01);
        wr_reg(A_CLR, 8'h01);
        rd_reg("lvl_pend_clr", A_PEND, 8'h01);
        @(negedge clk);
        src[0] = 1'b0;
        repeat (4) @(negedge clk);
        int_chk("lvl_int_off", 2'b11);
        rd_reg("lvl_pend_off", A_PEND, 8'h00);

        // Priority vector and software set
        wr_reg(A_ROUTE, 8'h10);
        wr_reg(A_MODE,  8'h1F);
        wr_reg(A_MASK,  8'h00);
        wr_reg(A_SWSET, 8'h18);
        rd_reg("sw_pend",      A_PEND, 8'h18);
        rd_reg("sw_vec_mask0", A_VEC,  8'h00);
        wr_reg(A_MASK, 8'h10);
        rd_reg("sw_vec4", A_VEC, 8'h84);
        int_chk("sw_int1_only", 2'b01);
        wr_reg(A_MASK, 8'h18);
        rd_reg("sw_vec3", A_VEC, 8'h83);
        int_chk("sw_int_both", 2'b00);
        wr_reg(A_CLR, 8'h18);
        rd_reg("sw_pend_clr", A_PEND, 8'h00);
        int_chk("sw_int_idle", 2'b11);

        // Set and clear colliding on one clk: set wins
        @(negedge clk);
        cs     = 1'b1;
        addr   = A_CLR;
        wdat   = 8'h08;
        wr     = 1'b1;
        src[3] = 1'b1;
        repeat (3) @(negedge clk);
        wr_end();
        src[3] = 1'b0;
        rd_reg("coll_pend", A_PEND, 8'h08);
        wr_reg(A_CLR, 8'h08);
        rd_reg("coll_pend_clr", A_PEND, 8'h00);

        // Long strobe commits once, with data sampled at the rise
        @(negedge clk);
        cs   = 1'b1;
        addr = A_MASK;
        wdat = 8'h01;
        wr   = 1'b1;
        repeat (5) @(negedge clk);
        wdat = 8'h02;
        repeat (5) @(negedge clk);
        wr_end();
        rd_reg("long_strobe_mask", A_MASK, 8'h01);
        wr_reg(A_MASK, 8'h1F, 1'b0);
        rd_reg("nocs_mask", A_MASK, 8'h01);

        // Read-side boundaries
        rd_reg("rd_clr",   A_CLR,   8'h00);
        rd_reg("rd_swset", A_SWSET, 8'h00);
        rd_reg("rd_off7",  4'd7,    8'h00);
        rd_reg("rd_offF",  4'hF,    8'h00);
        rd_reg("rd_nocs",  A_MODE,  8'h00, 1'b0);

        // Reset in the middle of a held strobe
        wr_reg(A_ROUTE, 8'h03);
        wr_reg(A_MODE,  8'h0A);
        wr_reg(A_SWSET, 8'h01);
        @(negedge clk);
        int_chk("pre_rst_int", 2'b01);
        @(negedge clk);
        cs   = 1'b1;
        addr = A_MASK;
        wdat = 8'h1F;
        wr   = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        int_chk("mid_rst_int", 2'b11);
        repeat (3) @(negedge clk);
        wr_end();
        rd_reg("mid_rst_mask",  A_MASK,  8'h00);
        rd_reg("mid_rst_mode",  A_MODE,  8'h1F);
        rd_reg("mid_rst_route", A_ROUTE, 8'h10);
        rd_reg("mid_rst_pend",  A_PEND,  8'h00);
        rd_reg("mid_rst_vec",   A_VEC,   8'h00);
        int_chk("mid_rst_int_after", 2'b11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
